// File: rtl/dispatch_window.sv
// Dispatch window: compacting buffer of renamed ops between rename and the type sorter.
// Optional statistics counters are enabled with `define DISPATCH_WINDOW_STATS_EN.
`ifndef RENAMED_OP_SZ
`define RENAMED_OP_SZ 16
`endif

module dispatch_window #(
   parameter int FETCH_WIDTH = 4,
   parameter int CNT_W       = $clog2(FETCH_WIDTH + 1)
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   flush,
   input  logic [FETCH_WIDTH*`RENAMED_OP_SZ-1:0]  in_ops,
   input  logic [CNT_W-1:0]                       in_count,
   input  logic                                   in_valid,
   output logic                                   in_ready,
   output logic [FETCH_WIDTH*`RENAMED_OP_SZ-1:0]  win_ops,
   output logic [FETCH_WIDTH-1:0]                 win_valid,
   input  logic [FETCH_WIDTH-1:0]                 win_used,
`ifdef DISPATCH_WINDOW_STATS_EN
   output logic [31:0]                            stat_stall_cycles,
   output logic [31:0]                            stat_full_reject,
`endif
   output logic [CNT_W-1:0]                       occupancy
);

   localparam int OP_SZ = `RENAMED_OP_SZ;

   logic [OP_SZ-1:0]       ops_q [FETCH_WIDTH];
   logic [OP_SZ-1:0]       ops_d [FETCH_WIDTH];
   logic [CNT_W-1:0]       occ_q;
   logic [CNT_W-1:0]       occ_d;

   logic [FETCH_WIDTH-1:0] valid_mask;
   logic [FETCH_WIDTH-1:0] used_eff;
   logic [FETCH_WIDTH-1:0] survive;
   logic [CNT_W-1:0]       used_cnt;
   logic [CNT_W-1:0]       surv_cnt;
   logic [CNT_W-1:0]       rem;
   logic [CNT_W-1:0]       dest [FETCH_WIDTH];
   logic [CNT_W:0]         need;
   logic                   accept;

   // Thermometer of live slots, and the survivors' packed destinations.
   always_comb begin
      valid_mask = '0;
      used_cnt   = '0;
      surv_cnt   = '0;
      for (int k = 0; k < FETCH_WIDTH; k++) begin
         valid_mask[k] = (CNT_W'(k) < occ_q);
      end
      used_eff = win_used & valid_mask;
      survive  = valid_mask & ~win_used;
      for (int k = 0; k < FETCH_WIDTH; k++) begin
         dest[k]  = surv_cnt;
         surv_cnt = surv_cnt + {{(CNT_W-1){1'b0}}, survive[k]};
         used_cnt = used_cnt + {{(CNT_W-1){1'b0}}, used_eff[k]};
      end
      rem  = occ_q - used_cnt;
      need = {1'b0, rem} + {1'b0, in_count};
   end

   // Freed slots are reusable in the same cycle, so win_used feeds in_ready directly.
   assign in_ready = ~rst & ~flush & (need <= (CNT_W+1)'(FETCH_WIDTH));
   assign accept   = in_valid & in_ready;

   always_comb begin
      for (int d = 0; d < FETCH_WIDTH; d++) begin
         ops_d[d] = '0;
      end
      for (int s = 0; s < FETCH_WIDTH; s++) begin
         for (int d = 0; d < FETCH_WIDTH; d++) begin
            if (survive[s] && (dest[s] == CNT_W'(d))) begin
               ops_d[d] = ops_q[s];
            end
         end
      end
      if (accept) begin
         for (int k = 0; k < FETCH_WIDTH; k++) begin
            for (int d = 0; d < FETCH_WIDTH; d++) begin
               if ((CNT_W'(k) < in_count) && ((rem + CNT_W'(k)) == CNT_W'(d))) begin
                  ops_d[d] = in_ops[k*OP_SZ +: OP_SZ];
               end
            end
         end
      end
      occ_d = accept ? (rem + in_count) : rem;
      if (flush) begin
         occ_d = '0;
         for (int d = 0; d < FETCH_WIDTH; d++) begin
            ops_d[d] = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         occ_q <= '0;
         for (int d = 0; d < FETCH_WIDTH; d++) begin
            ops_q[d] <= '0;
         end
      end else begin
         occ_q <= occ_d;
         for (int d = 0; d < FETCH_WIDTH; d++) begin
            ops_q[d] <= ops_d[d];
         end
      end
   end

   for (genvar g = 0; g < FETCH_WIDTH; g++) begin : g_out
      assign win_ops[g*OP_SZ +: OP_SZ] = ops_q[g];
   end
   assign win_valid = valid_mask;
   assign occupancy = occ_q;

`ifdef DISPATCH_WINDOW_STATS_EN
   logic [31:0] stall_q;
   logic [31:0] reject_q;
   logic        stall_inc;
   logic        reject_inc;

   assign stall_inc  = (occ_q != '0) && (used_eff == '0);
   assign reject_inc = in_valid & ~in_ready & ~flush & ~rst;

   // Both counters saturate at all-ones; flush leaves them alone.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_q  <= '0;
         reject_q <= '0;
      end else begin
         if (stall_inc && !(&stall_q)) stall_q <= stall_q + 32'd1;
         if (reject_inc && !(&reject_q)) reject_q <= reject_q + 32'd1;
      end
   end

   assign stat_stall_cycles = stall_q;
   assign stat_full_reject  = reject_q;
`endif

endmodule

// File: tb/tb_dispatch_window.sv
// Directed + random bench for dispatch_window with a queue-based window model and scoreboard.
`ifndef RENAMED_OP_SZ
`define RENAMED_OP_SZ 16
`endif

module tb_dispatch_window;
  localparam int FW     = 4;
  localparam int CW     = 3;
  localparam int OP_SZ  = `RENAMED_OP_SZ;
  localparam int SNAP_W = CW + FW + FW*OP_SZ;

  logic                  clk;
  logic                  rst;
  logic                  flush;
  logic [FW*OP_SZ-1:0]   in_ops;
  logic [CW-1:0]         in_count;
  logic                  in_valid;
  logic                  in_ready;
  logic [FW*OP_SZ-1:0]   win_ops;
  logic [FW-1:0]         win_valid;
  logic [FW-1:0]         win_used;
  logic [CW-1:0]         occupancy;
`ifdef DISPATCH_WINDOW_STATS_EN
  logic [31:0]           stat_stall_cycles;
  logic [31:0]           stat_full_reject;
`endif

  dispatch_window #(.FETCH_WIDTH(FW), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_ops    (in_ops),
    .in_count  (in_count),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .win_ops   (win_ops),
    .win_valid (win_valid),
    .win_used  (win_used),
`ifdef DISPATCH_WINDOW_STATS_EN
    .stat_stall_cycles (stat_stall_cycles),
    .stat_full_reject  (stat_full_reject),
`endif
    .occupancy (occupancy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  logic [SNAP_W-1:0] exp_q[$];
  logic [OP_SZ-1:0]  mq[$];

  localparam logic [OP_SZ-1:0] A = 16'h00A1, B = 16'h00B2, C = 16'h00C3, D = 16'h00D4;
  localparam logic [OP_SZ-1:0] E = 16'h00E5, F = 16'h00F6, G = 16'h0107;

  task automatic chk(input string tag, input logic [SNAP_W-1:0] obs, input logic [SNAP_W-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [FW*OP_SZ-1:0] live_ops(input logic [FW*OP_SZ-1:0] ops,
                                                   input logic [FW-1:0] v);
    logic [FW*OP_SZ-1:0] r;
    r = '0;
    for (int k = 0; k < FW; k++) if (v[k]) r[k*OP_SZ +: OP_SZ] = ops[k*OP_SZ +: OP_SZ];
    return r;
  endfunction

  function automatic logic [SNAP_W-1:0] model_snap();
    logic [FW-1:0]       v;
    logic [FW*OP_SZ-1:0] o;
    v = '0;
    o = '0;
    for (int k = 0; k < mq.size(); k++) begin
      v[k] = 1'b1;
      o[k*OP_SZ +: OP_SZ] = mq[k];
    end
    return {CW'(mq.size()), v, o};
  endfunction

  // driver
  task automatic drive(input logic v, input int cnt, input logic [OP_SZ-1:0] o0, o1, o2, o3,
                       input logic [FW-1:0] used);
    in_valid = v;
    in_count = CW'(cnt);
    in_ops   = {o3, o2, o1, o0};
    win_used = used;
  endtask

  // One clock: model update + in_ready check, push expectation, compare after the edge.
  task automatic cycle(input string tag);
    logic [OP_SZ-1:0]  nq[$];
    logic              ready;
    logic [SNAP_W-1:0] obs;
    #1;
    if (rst) begin
      ready = 1'b0;
      mq.delete();
    end else begin
      nq.delete();
      for (int i = 0; i < mq.size(); i++) if (!win_used[i]) nq.push_back(mq[i]);
      ready = !flush && ((nq.size() + int'(in_count)) <= FW);
      if (flush) mq.delete();
      else begin
        if (in_valid && ready)
          for (int k = 0; k < int'(in_count); k++) nq.push_back(in_ops[k*OP_SZ +: OP_SZ]);
        mq = nq;
      end
    end
    chk({tag, "/in_ready"}, SNAP_W'(in_ready), SNAP_W'(ready));
    exp_q.push_back(model_snap());
    @(posedge clk);
    #2;
    obs = {occupancy, win_valid, live_ops(win_ops, win_valid)};
    chk({tag, "/window"}, obs, exp_q.pop_front());
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    drive(1'b0, 0, '0, '0, '0, '0, '0);
    @(posedge clk);
    #2;
    chk("reset/occupancy", SNAP_W'(occupancy), '0);
    chk("reset/win_valid", SNAP_W'(win_valid), '0);
    chk("reset/win_ops", SNAP_W'(win_ops), '0);
    chk("reset/in_ready", SNAP_W'(in_ready), '0);
    rst = 1'b0;

    // 1: first group lands one cycle later
    drive(1'b1, 3, A, B, C, '0, 4'b0000);
    cycle("t1");
    chk("t1/occ_const", SNAP_W'(occupancy), SNAP_W'(3));
    chk("t1/valid_const", SNAP_W'(win_valid), SNAP_W'(4'b0111));

    // 2: non-prefix used pattern with same-cycle slot reuse
    drive(1'b1, 1, D, '0, '0, '0, 4'b0000);
    cycle("t2_fill");
    drive(1'b1, 2, E, F, '0, '0, 4'b0101);
    cycle("t2");
    chk("t2/ops_const", SNAP_W'(win_ops), SNAP_W'({F, E, D, B}));

    // 3: full window rejects, then one freed slot admits a single op
    flush = 1'b1;
    drive(1'b0, 0, '0, '0, '0, '0, '0);
    cycle("t3_flush");
    flush = 1'b0;
    drive(1'b1, 4, A, B, C, D, 4'b0000);
    cycle("t3_fill");
    drive(1'b1, 1, G, '0, '0, '0, 4'b0000);
    cycle("t3_full");
    drive(1'b1, 1, E, '0, '0, '0, 4'b1000);
    cycle("t3_free");
    chk("t3/ops_const", SNAP_W'(win_ops), SNAP_W'({E, C, B, A}));

    // 4: used bits above occupancy are ignored
    flush = 1'b1;
    drive(1'b0, 0, '0, '0, '0, '0, '0);
    cycle("t4_flush");
    flush = 1'b0;
    drive(1'b1, 2, A, B, '0, '0, 4'b0000);
    cycle("t4_fill");
    drive(1'b0, 0, '0, '0, '0, '0, 4'b1100);
    cycle("t4");
    chk("t4/occ_const", SNAP_W'(occupancy), SNAP_W'(2));

    // 5: flush drops the offered group; reset overrides an offer
    drive(1'b1, 1, C, '0, '0, '0, 4'b0000);
    cycle("t5_fill");
    flush = 1'b1;
    drive(1'b1, 2, D, E, '0, '0, 4'b0000);
    cycle("t5_flush");
    flush = 1'b0;
    drive(1'b1, 2, F, G, '0, '0, 4'b0000);
    cycle("t5_refill");
    rst = 1'b1;
    drive(1'b1, 2, A, B, '0, '0, 4'b0000);
    cycle("t5_rst");
    rst = 1'b0;
    drive(1'b1, 0, '0, '0, '0, '0, 4'b0000);
    cycle("t5_zero_count");

`ifdef DISPATCH_WINDOW_STATS_EN
    // 6: five stalled cycles with an oversized offer
    rst = 1'b1;
    drive(1'b0, 0, '0, '0, '0, '0, '0);
    cycle("t6_rst");
    rst = 1'b0;
    drive(1'b1, 2, A, B, '0, '0, 4'b0000);
    cycle("t6_fill");
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 3, C, D, E, '0, 4'b0000);
      cycle("t6_stall");
    end
    chk("t6/stall_cycles", SNAP_W'(stat_stall_cycles), SNAP_W'(5));
    chk("t6/full_reject", SNAP_W'(stat_full_reject), SNAP_W'(5));
`endif

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      rst   = ($urandom_range(0, 99) == 0);
      flush = ($urandom_range(0, 19) == 0);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, FW),
            OP_SZ'($urandom), OP_SZ'($urandom), OP_SZ'($urandom), OP_SZ'($urandom),
            FW'($urandom_range(0, 15)));
      cycle("rand");
    end
    rst   = 1'b0;
    flush = 1'b0;

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/dispatch_window.md
Name: dispatch_window

Overview:
- Holds up to FETCH_WIDTH renamed ops, oldest in slot 0, and presents them to the type sorter as a contiguous window.
- Each cycle, deletes the ops the sorter reports as used, compacts the survivors in program order, and appends a new group from rename.
- Sits between the rename stage and the type sorter, and sequences the sorter's input.

Parameters:
- FETCH_WIDTH, 4: window slots, which also sets the rename group width. Must be ≥2.
- CNT_W, $clog2(FETCH_WIDTH+1): width of occupancy and count fields.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  discard all window contents (mispredict or terminate redirect).
- in_ops  input  FETCH_WIDTH*`RENAMED_OP_SZ  rename group; op k at slice k, oldest is k=0.
- in_count  input  CNT_W  number of valid ops in the group, 0..FETCH_WIDTH. Ops are always in the low slices.
- in_valid  input  1  rename group offered.
- in_ready  output  1  group fits this cycle.
- win_ops  output  FETCH_WIDTH*`RENAMED_OP_SZ  window contents, driven to the sorter.
- win_valid  output  FETCH_WIDTH  thermometer mask; bit k set iff k < occupancy.
- win_used  input  FETCH_WIDTH  used mask returned by the sorter for this cycle.
- occupancy  output  CNT_W  registered count of valid slots.

Behaviour:
- State: FETCH_WIDTH op registers plus the occupancy register. win_ops and occupancy are registered; win_valid is decoded from occupancy.
- Reset:
  - occupancy=0, win_valid=0, all op registers=0.
  - in_ready=0 during the reset cycle.
- used_eff = win_used & win_valid. Bits of win_used above occupancy are ignored.
- rem = occupancy − popcount(used_eff). Computed combinationally from the current cycle's win_used.
- in_ready = ~rst & ~flush & (rem + in_count ≤ FETCH_WIDTH).
  - Combinational path from win_used to in_ready.
  - Zero-latency reuse of freed slots is required.
- Accept occurs when in_valid & in_ready.
- Next state, with priority rst > flush > normal:
  - flush: occupancy←0. The offered group is dropped (not accepted); used_eff is ignored.
  - normal:
    - Surviving slots (valid & ~used) are packed into slots 0..rem−1, preserving relative order. Arbitrary non-prefix used patterns are legal, e.g. 4'b0110.
    - If accepted, in_ops slices 0..in_count−1 are written to slots rem..rem+in_count−1.
    - occupancy ← rem + (accepted ? in_count : 0).
- in_valid with in_count=0 is a legal no-op accept, provided in_ready.
- Ops are never reordered, and an op is never duplicated or lost except by flush.
- Groups are atomic: a partially fitting group is not split, and in_ready stays low.
- Latency: an op accepted in cycle N appears on win_ops/win_valid in cycle N+1, at the earliest.
- Full window with no used ops: in_ready=0 for any in_count>0; contents hold.
- Empty window: win_valid=0, and win_used is ignored entirely.
- Invalid slots above occupancy: contents are don't-care but must not be X after reset. Implementation writes zero or holds.
- Reset asserted mid-operation overrides flush and accept in the same cycle.

Optional Feature:
- Macro DISPATCH_WINDOW_STATS_EN.
- When defined, adds outputs:
  - stat_stall_cycles (32 bits): increments each cycle with occupancy≠0 and used_eff=0.
  - stat_full_reject (32 bits): increments each cycle with in_valid & ~in_ready & ~flush & ~rst.
- Both counters are cleared by rst, are unaffected by flush, and saturate at all-ones.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Test Plan (FETCH_WIDTH=4):
1. Reset, then in_valid=1, in_count=3, ops A,B,C, win_used=0 -> next cycle occupancy=3, win_valid=4'b0111, slots A,B,C.
2. Window A,B,C,D; win_used=4'b0101; offer E,F (count 2) -> in_ready=1; next cycle window B,D,E,F, occupancy=4.
3. Window full A..D, win_used=0, offer count 1 -> in_ready=0, window unchanged; next cycle win_used=4'b1000 -> in_ready=1, window A,B,C,E.
4. Window A,B; win_used=4'b1100 (above occupancy) -> ignored; window stays A,B, occupancy=2.
5. Window A,B,C; flush=1 with in_valid=1, count 2 -> in_ready=0; next cycle occupancy=0. Then rst asserted together with in_valid -> occupancy=0, in_ready=0.
6. With DISPATCH_WINDOW_STATS_EN: hold occupancy=2 with win_used=0 for 5 cycles -> stat_stall_cycles=5. Offer count 3 for those same 5 cycles -> stat_full_reject=5, since rem=2 makes 2+3>4 so in_ready=0.
